// File: rtl/mult_div_if.sv
// mult_div_if: operand, control and HI/LO result signals between the core and the multiply/divide unit
interface mult_div_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;
  logic                  mthi;
  logic                  mtlo;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic                  busy;
  logic                  done;
  logic                  div_zero;
  modport master (output start, op, rs_data, rt_data, mthi, mtlo, input hi, lo, busy, done, div_zero);
  modport slave (input start, op, rs_data, rt_data, mthi, mtlo, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 33-cycle HI/LO multiply/divide unit (shift-add multiply, restoring divide)
module mult_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input logic       clk,
  input logic       rst,
  mult_div_if.slave bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;
  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [1:0]           r_op;
  logic                 r_sa, r_sb, r_done, r_dz;
  logic [W-1:0]         r_a, r_b, r_hi, r_lo;
  logic [2*W-1:0]       r_acc;
  logic                 w_sgn_in, w_sa, w_sb, w_dz;
  logic [W-1:0]         w_a, w_b, w_q, w_r, w_rs, w_hi, w_lo;
  logic [W:0]           w_sum, w_trial;
  logic [2*W-1:0]       w_calc, w_prod;
  // Operands are held as magnitudes; signs only matter again in FIX
  always_comb begin
    w_sgn_in = ~bus.op[0];
    w_sa     = w_sgn_in & bus.rs_data[W-1];
    w_sb     = w_sgn_in & bus.rt_data[W-1];
    w_a      = w_sa ? -bus.rs_data : bus.rs_data;
    w_b      = w_sb ? -bus.rt_data : bus.rt_data;
    w_sum    = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_a};
    w_trial  = r_acc[2*W-1:W-1] - {1'b0, r_b};
    w_calc   = r_op[1] ? (w_trial[W] ? {r_acc[2*W-2:0], 1'b0} : {w_trial[W-1:0], r_acc[W-2:0], 1'b1})
                       : (r_acc[0] ? {w_sum, r_acc[W-1:1]} : {1'b0, r_acc[2*W-1:1]});
    w_prod   = (r_sa ^ r_sb) ? -r_acc : r_acc;
    w_q      = r_acc[W-1:0];
    w_r      = r_acc[2*W-1:W];
    w_rs     = r_sa ? -r_a : r_a;
    w_dz     = r_op[1] & (r_b == '0);
    w_hi     = r_op[1] ? (w_dz ? w_rs : (r_sa ? -w_r : w_r)) : w_prod[2*W-1:W];
    w_lo     = r_op[1] ? (w_dz ? '1 : ((r_sa ^ r_sb) ? -w_q : w_q)) : w_prod[W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.start) begin
          r_state <= CALC;
          r_cnt   <= '0;
          r_op    <= bus.op;
          r_sa    <= w_sa;
          r_sb    <= w_sb;
          r_a     <= w_a;
          r_b     <= w_b;
          r_acc   <= {{W{1'b0}}, bus.op[1] ? w_a : w_b};
        end else begin
          if (bus.mthi) r_hi <= bus.rs_data;
          if (bus.mtlo) r_lo <= bus.rs_data;
        end
      end else if (r_state == CALC) begin
        r_acc <= w_calc;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == '1) r_state <= FIX;
      end else begin
        r_hi    <= w_hi;
        r_lo    <= w_lo;
        r_done  <= 1'b1;
        r_dz    <= w_dz;
        r_state <= IDLE;
      end
    end
  end
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.busy     = r_state != IDLE;
  assign bus.done     = r_done;
  assign bus.div_zero = r_dz;
endmodule
